// File: rtl/flash_insn_fetch.sv
// flash_insn_fetch
//   Fetches 16-bit Gigatron instructions from an 8-bit parallel flash, two
//   byte reads per word (low byte first), and hands them to the CPU with a
//   ready flag. A one-word prefetch of addr+1 lets straight-line code be
//   delivered one edge after the request.
//
// Ports
//   CLOCK_50    in   system clock, all logic on posedge
//   reset       in   asynchronous, active-high reset
//   fetch_req   in   one-cycle request strobe, sampled only while busy=0
//   fetch_addr  in   [15:0] word address, sampled with fetch_req
//   insn        out  [15:0] fetched instruction {hi, lo}, valid while insn_rdy=1
//   insn_rdy    out  insn valid for the last accepted request
//   busy        out  demand fetch in progress; fetch_req is ignored
//   FL_ADDR     out  [21:0] flash byte address
//   FL_DQ       in   [7:0] flash data
//   FL_CE_N     out  flash chip enable, active low
//   FL_OE_N     out  flash output enable, active low
//
// Handshake: a request is accepted on the edge where fetch_req=1 and busy=0.
// That edge clears insn_rdy. insn_rdy then rises when the word is available
// and stays high, with insn stable, until the next accepted request.
module flash_insn_fetch #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [21:0] ROM_BASE    = 22'h0,
    parameter bit          PREFETCH    = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic [15:0] insn,
    output logic        insn_rdy,
    output logic        busy,
    output logic [21:0] FL_ADDR,
    input  logic [7:0]  FL_DQ,
    output logic        FL_CE_N,
    output logic        FL_OE_N
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_PF_LO = 3'd3,
        S_PF_HI = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic          accept;
    logic          hit;
    logic          hit_pend;
    logic [15:0]   req_addr;
    logic [15:0]   pf_addr;
    logic [15:0]   pf_data;
    logic          pf_valid;
    logic [7:0]    lo_byte;

    function automatic logic [21:0] byte_addr(input logic [15:0] word, input logic b);
        return ROM_BASE + {5'd0, word, b};
    endfunction

    // cnt is 1 on the edge after an address is driven, so cnt==WAIT_CYCLES
    // marks the edge on which the byte has been held for WAIT_CYCLES cycles.
    assign cnt_done = (cnt == CW'(WAIT_CYCLES));
    assign accept   = fetch_req && !busy;
    // pf_valid is only ever set in IDLE, so a request landing on an
    // in-flight prefetch is a miss and restarts from byte 0.
    assign hit      = accept && pf_valid && (fetch_addr == pf_addr);

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = hit ? (PREFETCH ? S_PF_LO : S_IDLE) : S_LO;
            end
            S_LO: begin
                if (cnt_done) state_nxt = S_HI;
            end
            S_HI: begin
                if (cnt_done) state_nxt = PREFETCH ? S_PF_LO : S_IDLE;
            end
            S_PF_LO: begin
                if (accept)        state_nxt = S_LO;
                else if (cnt_done) state_nxt = S_PF_HI;
            end
            S_PF_HI: begin
                if (accept)        state_nxt = S_LO;
                else if (cnt_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == S_LO) || (state == S_HI);
    end

    // Datapath: flash address, byte capture, prefetch buffer, insn/insn_rdy
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            insn     <= 16'h0;
            insn_rdy <= 1'b0;
            FL_ADDR  <= 22'h0;
            FL_CE_N  <= 1'b1;
            FL_OE_N  <= 1'b1;
            cnt      <= '0;
            hit_pend <= 1'b0;
            req_addr <= 16'h0;
            pf_addr  <= 16'h0;
            pf_data  <= 16'h0;
            pf_valid <= 1'b0;
            lo_byte  <= 8'h0;
        end else begin
            // Read-only device: permanently selected once out of reset.
            FL_CE_N  <= 1'b0;
            FL_OE_N  <= 1'b0;
            hit_pend <= 1'b0;
            // A hit presents its word one edge after acceptance.
            if (hit_pend) insn_rdy <= 1'b1;

            if (accept) begin
                insn_rdy <= 1'b0;
                pf_valid <= 1'b0;
                cnt      <= CW'(1);
                if (hit) begin
                    insn     <= pf_data;
                    hit_pend <= 1'b1;
                    if (PREFETCH) begin
                        pf_addr <= fetch_addr + 16'd1;
                        FL_ADDR <= byte_addr(fetch_addr + 16'd1, 1'b0);
                    end
                end else begin
                    req_addr <= fetch_addr;
                    FL_ADDR  <= byte_addr(fetch_addr, 1'b0);
                end
            end else begin
                case (state)
                    S_LO: begin
                        if (cnt_done) begin
                            lo_byte <= FL_DQ;
                            FL_ADDR <= byte_addr(req_addr, 1'b1);
                            cnt     <= CW'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_HI: begin
                        if (cnt_done) begin
                            insn     <= {FL_DQ, lo_byte};
                            insn_rdy <= 1'b1;
                            cnt      <= CW'(1);
                            if (PREFETCH) begin
                                pf_addr <= req_addr + 16'd1;
                                FL_ADDR <= byte_addr(req_addr + 16'd1, 1'b0);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_PF_LO: begin
                        if (cnt_done) begin
                            lo_byte <= FL_DQ;
                            FL_ADDR <= byte_addr(pf_addr, 1'b1);
                            cnt     <= CW'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_PF_HI: begin
                        if (cnt_done) begin
                            pf_data  <= {FL_DQ, lo_byte};
                            pf_valid <= 1'b1;
                            cnt      <= CW'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_insn_fetch.sv
module tb_flash_insn_fetch;

    localparam int          W_M  = 5;
    localparam logic [21:0] B_M  = 22'h0;
    localparam int          W_N  = 3;
    localparam logic [21:0] B_N  = 22'h3E0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // prefetching instance
    logic        req_m = 1'b0;
    logic [15:0] addr_m = 16'h0;
    logic [15:0] insn_m;
    logic        rdy_m, busy_m, ce_m, oe_m;
    logic [21:0] fla_m;
    logic [7:0]  dq_m;

    // non-prefetching instance with a base near the top of flash
    logic        req_n = 1'b0;
    logic [15:0] addr_n = 16'h0;
    logic [15:0] insn_n;
    logic        rdy_n, busy_n, ce_n, oe_n;
    logic [21:0] fla_n;
    logic [7:0]  dq_n;

    // reference model state for the prefetching instance (absolute edge numbers)
    bit          m_pf_any;
    logic [15:0] m_pf_word;
    int          m_pf_done;
    int          m_busy_until;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] flash_byte(input logic [21:0] a);
        case (a)
            22'd0:   return 8'h34;
            22'd1:   return 8'h12;
            22'd2:   return 8'hCD;
            22'd3:   return 8'hAB;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int base, input int a);
        int lo_a;
        int hi_a;
        lo_a = (base + 2 * a) % 4194304;
        hi_a = (base + 2 * a + 1) % 4194304;
        return {flash_byte(22'(hi_a)), flash_byte(22'(lo_a))};
    endfunction

    assign dq_m = flash_byte(fla_m);
    assign dq_n = flash_byte(fla_n);

    flash_insn_fetch #(.WAIT_CYCLES(W_M), .ROM_BASE(B_M), .PREFETCH(1'b1)) dut (
        .CLOCK_50(clk), .reset(rst), .fetch_req(req_m), .fetch_addr(addr_m),
        .insn(insn_m), .insn_rdy(rdy_m), .busy(busy_m), .FL_ADDR(fla_m),
        .FL_DQ(dq_m), .FL_CE_N(ce_m), .FL_OE_N(oe_m)
    );

    flash_insn_fetch #(.WAIT_CYCLES(W_N), .ROM_BASE(B_N), .PREFETCH(1'b0)) dut_np (
        .CLOCK_50(clk), .reset(rst), .fetch_req(req_n), .fetch_addr(addr_n),
        .insn(insn_n), .insn_rdy(rdy_n), .busy(busy_n), .FL_ADDR(fla_n),
        .FL_DQ(dq_n), .FL_CE_N(ce_n), .FL_OE_N(oe_n)
    );

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        m_pf_any     = 1'b0;
        m_pf_word    = 16'h0;
        m_pf_done    = 0;
        m_busy_until = -1;
    endtask

    // Timing model: a miss takes 2W edges and its prefetch is usable after
    // 4W edges; a hit takes 1 edge and its prefetch is usable after 2W edges.
    task automatic model_req(input logic [15:0] a, input int t, output bit ign, output int lat);
        bit is_hit;
        ign = (t <= m_busy_until);
        lat = 0;
        if (!ign) begin
            is_hit = m_pf_any && (a == m_pf_word) && (t > m_pf_done);
            lat = is_hit ? 1 : 2 * W_M;
            m_pf_any  = 1'b1;
            m_pf_word = a + 16'd1;
            m_pf_done = is_hit ? t + 2 * W_M : t + 4 * W_M;
            if (!is_hit) m_busy_until = t + 2 * W_M;
        end
    endtask

    // Drives a one-cycle strobe; t returns the edge number that sampled it.
    task automatic issue(input bit np, input logic [15:0] a, output int t);
        @(negedge clk);
        if (np) begin req_n = 1'b1; addr_n = a; end
        else    begin req_m = 1'b1; addr_m = a; end
        @(negedge clk);
        req_n = 1'b0; req_m = 1'b0;
        addr_n = 16'($urandom); addr_m = 16'($urandom);
        t = cyc;
    endtask

    // Waits for insn_rdy; lat = edges since acceptance, -1 on timeout.
    task automatic wait_ready(input bit np, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((np ? rdy_n : rdy_m) === 1'b1) begin
                lat = cyc - t0;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({insn_m, rdy_m, busy_m} !== 18'h0) $display("FAIL reset_out: got %h expected 0", {insn_m, rdy_m, busy_m}); else n_pass++;
        n_chk++; if (fla_m !== 22'h0) $display("FAIL reset_fladdr: got %h expected 0", fla_m); else n_pass++;
        n_chk++; if ({ce_m, oe_m, ce_n, oe_n} !== 4'hF) $display("FAIL reset_ce_oe: got %b expected 1111", {ce_m, oe_m, ce_n, oe_n}); else n_pass++;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++; if ({ce_m, oe_m, ce_n, oe_n} !== 4'h0) $display("FAIL post_reset_ce_oe: got %b expected 0000", {ce_m, oe_m, ce_n, oe_n}); else n_pass++;
    endtask

    task automatic test_miss();
        int t, lat; bit ign; int el;
        issue(1'b0, 16'h0000, t);
        model_req(16'h0000, t, ign, el);
        n_chk++; if (busy_m !== 1'b1) $display("FAIL miss_busy: got %b expected 1", busy_m); else n_pass++;
        n_chk++; if (rdy_m !== 1'b0) $display("FAIL miss_rdy_clear: got %b expected 0", rdy_m); else n_pass++;
        repeat (W_M - 1) @(negedge clk);
        n_chk++; if (fla_m !== 22'd0) $display("FAIL miss_fladdr_lo: got %h expected 0", fla_m); else n_pass++;
        @(negedge clk);
        n_chk++; if (fla_m !== 22'd1) $display("FAIL miss_fladdr_hi: got %h expected 1", fla_m); else n_pass++;
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 10) $display("FAIL miss_latency: got %0d expected 10", lat); else n_pass++;
        n_chk++; if (insn_m !== 16'h1234) $display("FAIL miss_insn: got %h expected 1234", insn_m); else n_pass++;
        n_chk++; if (busy_m !== 1'b0) $display("FAIL miss_busy_drop: got %b expected 0", busy_m); else n_pass++;
    endtask

    task automatic test_hit();
        int t, lat; bit ign; int el;
        repeat (12) @(negedge clk);
        issue(1'b0, 16'h0001, t);
        model_req(16'h0001, t, ign, el);
        n_chk++; if ({rdy_m, busy_m} !== 2'b00) $display("FAIL hit_edge0: got rdy,busy=%b expected 00", {rdy_m, busy_m}); else n_pass++;
        n_chk++; if (fla_m !== 22'd4) $display("FAIL hit_pf_addr: got %h expected 4", fla_m); else n_pass++;
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 1) $display("FAIL hit_latency: got %0d expected 1", lat); else n_pass++;
        n_chk++; if (insn_m !== 16'hABCD) $display("FAIL hit_insn: got %h expected abcd", insn_m); else n_pass++;
        repeat (W_M - 1) @(negedge clk);
        n_chk++; if (fla_m !== 22'd5) $display("FAIL hit_pf_addr_hi: got %h expected 5", fla_m); else n_pass++;
    endtask

    task automatic test_wrap();
        int t, lat; bit ign; int el;
        repeat (2 * W_M + 2) @(negedge clk);
        issue(1'b0, 16'hFFFF, t);
        model_req(16'hFFFF, t, ign, el);
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== el) $display("FAIL wrap_miss_latency: got %0d expected %0d", lat, el); else n_pass++;
        n_chk++; if (insn_m !== exp_word(int'(B_M), 16'hFFFF)) $display("FAIL wrap_miss_insn: got %h expected %h", insn_m, exp_word(int'(B_M), 16'hFFFF)); else n_pass++;
        n_chk++; if (fla_m !== 22'd0) $display("FAIL wrap_pf_addr_lo: got %h expected 0", fla_m); else n_pass++;
        repeat (W_M) @(negedge clk);
        n_chk++; if (fla_m !== 22'd1) $display("FAIL wrap_pf_addr_hi: got %h expected 1", fla_m); else n_pass++;
        repeat (W_M + 1) @(negedge clk);
        issue(1'b0, 16'h0000, t);
        model_req(16'h0000, t, ign, el);
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 1) $display("FAIL wrap_hit_latency: got %0d expected 1", lat); else n_pass++;
        n_chk++; if (insn_m !== 16'h1234) $display("FAIL wrap_hit_insn: got %h expected 1234", insn_m); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int t, t2, lat; bit ign; int el;
        repeat (2 * W_M + 2) @(negedge clk);
        issue(1'b0, 16'h0005, t);
        model_req(16'h0005, t, ign, el);
        repeat (2) @(negedge clk);
        issue(1'b0, 16'h0009, t2);
        model_req(16'h0009, t2, ign, el);
        n_chk++; if (busy_m !== 1'b1) $display("FAIL ignore_busy: got %b expected 1", busy_m); else n_pass++;
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 10) $display("FAIL ignore_latency: got %0d expected 10", lat); else n_pass++;
        n_chk++; if (insn_m !== exp_word(int'(B_M), 5)) $display("FAIL ignore_insn: got %h expected %h", insn_m, exp_word(int'(B_M), 5)); else n_pass++;
        repeat (3) @(negedge clk);
        issue(1'b0, 16'h0009, t);
        model_req(16'h0009, t, ign, el);
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 10) $display("FAIL abort_pf_latency: got %0d expected 10", lat); else n_pass++;
        n_chk++; if (insn_m !== exp_word(int'(B_M), 9)) $display("FAIL abort_pf_insn: got %h expected %h", insn_m, exp_word(int'(B_M), 9)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t, lat; bit ign; int el;
        repeat (2 * W_M + 2) @(negedge clk);
        issue(1'b0, 16'h0042, t);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if ({rdy_m, busy_m} !== 2'b00) $display("FAIL rst_mid_rdy_busy: got %b expected 00", {rdy_m, busy_m}); else n_pass++;
        n_chk++; if ({ce_m, oe_m} !== 2'b11) $display("FAIL rst_mid_ce_oe: got %b expected 11", {ce_m, oe_m}); else n_pass++;
        n_chk++; if (fla_m !== 22'h0) $display("FAIL rst_mid_fladdr: got %h expected 0", fla_m); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        issue(1'b0, 16'h0042, t);
        model_req(16'h0042, t, ign, el);
        wait_ready(1'b0, t, lat);
        n_chk++; if (lat !== 10) $display("FAIL rst_refetch_latency: got %0d expected 10", lat); else n_pass++;
        n_chk++; if (insn_m !== exp_word(int'(B_M), 16'h42)) $display("FAIL rst_refetch_insn: got %h expected %h", insn_m, exp_word(int'(B_M), 16'h42)); else n_pass++;
    endtask

    task automatic test_no_prefetch();
        int t, lat;
        logic [21:0] held;
        logic [15:0] seq [4];
        seq[0] = 16'hFFFF; seq[1] = 16'h0000; seq[2] = 16'h0001; seq[3] = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, seq[k], t);
            if (k == 0) begin
                n_chk++; if (fla_n !== 22'h00000E) $display("FAIL np_wrap_fladdr: got %h expected 00000e", fla_n); else n_pass++;
            end
            n_chk++; if (busy_n !== 1'b1) $display("FAIL np_busy_%0d: got %b expected 1", k, busy_n); else n_pass++;
            wait_ready(1'b1, t, lat);
            n_chk++; if (lat !== 2 * W_N) $display("FAIL np_latency_%0d: got %0d expected %0d", k, lat, 2 * W_N); else n_pass++;
            n_chk++; if (insn_n !== exp_word(int'(B_N), int'(seq[k]))) $display("FAIL np_insn_%0d: got %h expected %h", k, insn_n, exp_word(int'(B_N), int'(seq[k]))); else n_pass++;
            held = fla_n;
            repeat (10) @(negedge clk);
            n_chk++; if (fla_n !== held || rdy_n !== 1'b1) $display("FAIL np_idle_%0d: got addr %h rdy %b expected addr %h rdy 1", k, fla_n, rdy_n, held); else n_pass++;
        end
    endtask

    task automatic test_random();
        int t, lat, el, gap;
        bit ign;
        logic [15:0] a;
        logic [15:0] last;
        last = 16'h0042;
        for (int i = 0; i < 40; i++) begin
            a   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : last + 16'd1;
            gap = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(2 * W_M, 25);
            repeat (gap) @(negedge clk);
            issue(1'b0, a, t);
            model_req(a, t, ign, el);
            if (!ign) begin
                wait_ready(1'b0, t, lat);
                n_chk++; if (lat !== el) $display("FAIL rand_latency_%0d: addr %h got %0d expected %0d", i, a, lat, el); else n_pass++;
                n_chk++; if (insn_m !== exp_word(int'(B_M), int'(a))) $display("FAIL rand_insn_%0d: addr %h got %h expected %h", i, a, insn_m, exp_word(int'(B_M), int'(a))); else n_pass++;
                last = a;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_miss();
        test_hit();
        test_wrap();
        test_busy_ignore();
        test_reset_mid();
        test_no_prefetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
